// File: rtl/sm_imem_loader.sv
// Framed byte-stream loader for the CPU instruction RAM; holds the core in reset until an image is written.
// Optional trailing checksum byte: define SM_LOADER_CHECKSUM_EN.
module sm_imem_loader #(
  parameter int         ADDR_WIDTH = 6,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5,
  parameter int         TIMEOUT    = 50000,
  parameter int         BOOT_HOLD  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  im_we,
  output logic [ADDR_WIDTH-1:0] im_addr,
  output logic [31:0]           im_wdata,
  output logic                  cpu_rst_n,
  output logic                  busy,
  output logic                  err,
  output logic [15:0]           words_loaded
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR
`ifdef SM_LOADER_CHECKSUM_EN
    , CHK
`endif
  } loaderState;

  loaderState    state, nextState;
  logic [15:0]   len;
  logic [15:0]   lenNext;
  logic [16:0]   wordCnt;
  logic [1:0]    byteCnt;
  logic [TW-1:0] idleCnt;
  logic          accept;
  logic          counting;
  logic          timedOut;
`ifdef SM_LOADER_CHECKSUM_EN
  logic [7:0]    csum;
`endif

  assign im_addr      = wordCnt[ADDR_WIDTH-1:0];
  assign words_loaded = wordCnt[15:0];
  assign lenNext      = {rx_data, len[7:0]};

  // NOTE: every output of this block gets a default first so no path can leave one unassigned and infer a latch.
  always_comb begin
    nextState = state;
    rx_ready  = (state != WRITE);
    im_we     = (state == WRITE);
    err       = (state == ERR);
    busy      = 1'b0;
    counting  = 1'b0;
    accept    = rx_valid && rx_ready;

    case (state)
      IDLE, DONE, ERR: begin
        if (accept && rx_data == SYNC_BYTE) nextState = LEN_LO;
      end
      LEN_LO: begin
        busy = 1'b1;
        counting = 1'b1;
        if (accept) nextState = LEN_HI;
      end
      LEN_HI: begin
        busy = 1'b1;
        counting = 1'b1;
        if (accept) begin
          if ({1'b0, lenNext} > 17'(DEPTH)) nextState = ERR;
`ifdef SM_LOADER_CHECKSUM_EN
          else if (lenNext == 16'd0)        nextState = CHK;
`else
          else if (lenNext == 16'd0)        nextState = DONE;
`endif
          else                              nextState = DATA;
        end
      end
      DATA: begin
        busy = 1'b1;
        counting = 1'b1;
        if (accept && byteCnt == 2'd3) nextState = WRITE;
      end
      WRITE: begin
        busy = 1'b1;
        if (wordCnt + 17'd1 == {1'b0, len}) begin
`ifdef SM_LOADER_CHECKSUM_EN
          nextState = CHK;
`else
          nextState = DONE;
`endif
        end else begin
          nextState = DATA;
        end
      end
`ifdef SM_LOADER_CHECKSUM_EN
      CHK: begin
        busy = 1'b1;
        counting = 1'b1;
        if (accept) nextState = (rx_data == csum) ? DONE : ERR;
      end
`endif
      default: nextState = IDLE;
    endcase

    // Timeout is evaluated after the byte-driven decision so it wins only on an empty cycle.
    timedOut = (TIMEOUT != 0) && counting && !accept && (idleCnt == TIMEOUT_LAST);
    if (timedOut) nextState = ERR;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      len       <= '0;
      wordCnt   <= '0;
      byteCnt   <= '0;
      idleCnt   <= '0;
      im_wdata  <= '0;
      cpu_rst_n <= (BOOT_HOLD == 0);
`ifdef SM_LOADER_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      state <= nextState;

      if (accept)                                  idleCnt <= '0;
      else if (counting && idleCnt != TIMEOUT_LAST) idleCnt <= idleCnt + 1'b1;

      case (state)
        IDLE, DONE, ERR: begin
          if (accept && rx_data == SYNC_BYTE) begin
            wordCnt   <= '0;
            byteCnt   <= '0;
            len       <= '0;
            cpu_rst_n <= 1'b0;
`ifdef SM_LOADER_CHECKSUM_EN
            csum      <= '0;
`endif
          end else if (state == DONE) begin
            cpu_rst_n <= 1'b1;
          end else if (state == ERR) begin
            cpu_rst_n <= 1'b0;
          end
        end
        LEN_LO: if (accept) len[7:0]  <= rx_data;
        LEN_HI: if (accept) len[15:8] <= rx_data;
        DATA: begin
          if (accept) begin
            im_wdata[{byteCnt, 3'b000} +: 8] <= rx_data;
            byteCnt <= byteCnt + 2'd1;
`ifdef SM_LOADER_CHECKSUM_EN
            csum    <= csum + rx_data;
`endif
          end
        end
        WRITE: wordCnt <= wordCnt + 17'd1;
        default: ;
      endcase
    end
  end

endmodule
